// File: rtl/phase_a_scheduler.sv
// Round-robin front end for one shared phase_a reduction unit: owns the modulus
// configuration, hands one operand at a time to the unit and returns its result.
module phase_a_scheduler #(
   parameter int Size    = 3072,
   parameter int radix   = 54,
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 255,
   parameter int GAP     = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_we,
   input  logic [Size-1:0]           cfg_m,
   input  logic [Size+1:0]           cfg_m_n,
   input  logic [radix+1:0]          cfg_m_prime,
   output logic                      cfg_busy,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*Size-1:0]   req_a,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [Size-1:0]           rsp_data,
   output logic                      rsp_err,
   output logic [Size-1:0]           pa_a,
   output logic [Size-1:0]           pa_m,
   output logic [Size+1:0]           pa_m_n,
   output logic [radix+1:0]          pa_m_prime,
   output logic                      pa_en,
   input  logic [Size-1:0]           pa_new_a,
   input  logic                      pa_en_out
);

   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam int GW = (GAP < 2) ? 1 : $clog2(GAP);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP, S_GAP} state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [TW-1:0]     wd_cnt_q, wd_cnt_d;
   logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
   logic [Size-1:0]   pa_a_q, pa_a_d;
   logic              pa_en_q, pa_en_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [Size-1:0]   rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic [Size-1:0]   cfg_m_q, cfg_m_d;
   logic [Size+1:0]   cfg_m_n_q, cfg_m_n_d;
   logic [radix+1:0]  cfg_m_prime_q, cfg_m_prime_d;

   logic              grant_found;
   logic [ID_W-1:0]   grant_idx;
   logic [ID_W-1:0]   cand;

   // First pending requester at or after the pointer, wrapping.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign cfg_busy  = (state_q != S_IDLE) | (|req_valid);
   assign req_ready = (state_q == S_IDLE && grant_found && !rst)
                      ? (NUM_REQ'(1) << grant_idx) : '0;

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      wd_cnt_d      = wd_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      pa_a_d        = pa_a_q;
      pa_en_d       = pa_en_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_id_d      = rsp_id_q;
      rsp_data_d    = rsp_data_q;
      rsp_err_d     = rsp_err_q;
      cfg_m_d       = cfg_m_q;
      cfg_m_n_d     = cfg_m_n_q;
      cfg_m_prime_d = cfg_m_prime_q;

      // Busy covers any pending request, so a load can never race a grant.
      if (cfg_we && !cfg_busy) begin
         cfg_m_d       = cfg_m;
         cfg_m_n_d     = cfg_m_n;
         cfg_m_prime_d = cfg_m_prime;
      end

      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               pa_a_d   = req_a[int'(grant_idx)*Size +: Size];
               rsp_id_d = grant_idx;
               pa_en_d  = 1'b1;
               wd_cnt_d = '0;
               rr_ptr_d = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            if (pa_en_out) begin
               rsp_data_d  = pa_new_a;
               rsp_err_d   = 1'b0;
               pa_en_d     = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else if (wd_cnt_q == TW'(TIMEOUT)) begin
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               pa_en_d     = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               gap_cnt_d   = '0;
               state_d     = (GAP == 0) ? S_IDLE : S_GAP;
            end
         end
         S_GAP: begin
            // Enable stays low long enough for the unit's edge detector to re-arm.
            if (gap_cnt_q == GW'(GAP - 1)) state_d = S_IDLE;
            else                           gap_cnt_d = gap_cnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so every
   // flop samples the values computed before the edge.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and clears every register, wide datapath included,
      // so nothing stale can leak out after an abandoned operation.
      if (rst) begin
         state_q       <= S_IDLE;
         rr_ptr_q      <= '0;
         wd_cnt_q      <= '0;
         gap_cnt_q     <= '0;
         pa_a_q        <= '0;
         pa_en_q       <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= '0;
         rsp_data_q    <= '0;
         rsp_err_q     <= 1'b0;
         cfg_m_q       <= '0;
         cfg_m_n_q     <= '0;
         cfg_m_prime_q <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         wd_cnt_q      <= wd_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         pa_a_q        <= pa_a_d;
         pa_en_q       <= pa_en_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_data_q    <= rsp_data_d;
         rsp_err_q     <= rsp_err_d;
         cfg_m_q       <= cfg_m_d;
         cfg_m_n_q     <= cfg_m_n_d;
         cfg_m_prime_q <= cfg_m_prime_d;
      end
   end

   assign pa_a       = pa_a_q;
   assign pa_en      = pa_en_q;
   assign pa_m       = cfg_m_q;
   assign pa_m_n     = cfg_m_n_q;
   assign pa_m_prime = cfg_m_prime_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_phase_a_scheduler.sv
// Directed bench for phase_a_scheduler with a behavioural phase_a unit that
// answers pa_a + OFF a fixed number of cycles after enable.
module tb_phase_a_scheduler;

   localparam int Size    = 3072;
   localparam int radix   = 54;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int TIMEOUT = 255;
   localparam int GAP     = 2;

   localparam logic [Size-1:0]  OFF     = Size'(64'h5A5A_0001);
   localparam logic [Size-1:0]  M       = {{(Size-4){1'b1}}, 4'h1};
   localparam logic [radix+1:0] M_PRIME = (radix+2)'(3);

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    cfg_we;
   logic [Size-1:0]         cfg_m;
   logic [Size+1:0]         cfg_m_n;
   logic [radix+1:0]        cfg_m_prime;
   logic                    cfg_busy;
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ*Size-1:0] req_a;
   logic [NUM_REQ-1:0]      req_ready;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [ID_W-1:0]         rsp_id;
   logic [Size-1:0]         rsp_data;
   logic                    rsp_err;
   logic [Size-1:0]         pa_a;
   logic [Size-1:0]         pa_m;
   logic [Size+1:0]         pa_m_n;
   logic [radix+1:0]        pa_m_prime;
   logic                    pa_en;
   logic [Size-1:0]         pa_new_a;
   logic                    pa_en_out;
   logic                    model_en_out;
   logic                    extra_en_out;
   logic                    model_on;
   int                      model_lat;
   logic [Size+1:0]         m_n_exp;

   int checks = 0;
   int errors = 0;

   assign pa_en_out = model_en_out | extra_en_out;

   always #5 clk = ~clk;

   phase_a_scheduler #(
      .Size(Size), .radix(radix), .NUM_REQ(NUM_REQ), .ID_W(ID_W),
      .TIMEOUT(TIMEOUT), .GAP(GAP)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_m(cfg_m), .cfg_m_n(cfg_m_n), .cfg_m_prime(cfg_m_prime),
      .cfg_busy(cfg_busy),
      .req_valid(req_valid), .req_a(req_a), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .pa_a(pa_a), .pa_m(pa_m), .pa_m_n(pa_m_n), .pa_m_prime(pa_m_prime),
      .pa_en(pa_en), .pa_new_a(pa_new_a), .pa_en_out(pa_en_out)
   );

   // Unit model: counts enabled cycles and pulses en_out on the model_lat-th one.
   initial begin
      int cnt;
      cnt = 0;
      model_en_out = 1'b0;
      pa_new_a = '0;
      forever begin
         @(negedge clk);
         if (pa_en) begin
            cnt++;
            if (model_on && cnt == model_lat) begin
               model_en_out = 1'b1;
               pa_new_a = pa_a + OFF;
            end else begin
               model_en_out = 1'b0;
            end
         end else begin
            cnt = 0;
            model_en_out = 1'b0;
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [Size-1:0] opnd(input int i);
      logic [Size-1:0] v;
      v = '0;
      v[Size-1] = 1'b1;
      v[31:0] = 32'h1000 + 32'(i);
      return v;
   endfunction

   task automatic start_req(input int id, input logic [Size-1:0] a);
      req_a[id*Size +: Size] = a;
      req_valid[id] = 1'b1;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (req_ready == '0 && n < 400) begin
         @(negedge clk); #1;
         n++;
      end
      checks++;
      if (req_ready == '0) begin
         errors++;
         $display("FAIL %s_grant: no req_ready within 400 cycles", tag);
      end
   endtask

   task automatic wait_rsp(input string tag);
      int n;
      n = 0;
      while (!rsp_valid && n < 400) begin
         @(negedge clk); #1;
         n++;
      end
      checks++;
      if (!rsp_valid) begin
         errors++;
         $display("FAIL %s_rsp: no rsp_valid within 400 cycles", tag);
      end
   endtask

   // Cycles after a response handshake before the next grant appears.
   task automatic measure_gap(output int gap, output bit bad);
      gap = 0;
      bad = 1'b0;
      do begin
         @(negedge clk); #1;
         if (req_ready != '0) break;
         if (pa_en || rsp_valid) bad = 1'b1;
         gap++;
      end while (gap < 20);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({pa_en, rsp_valid, rsp_err, rsp_id, req_ready, cfg_busy} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 0",
                  {pa_en, rsp_valid, rsp_err, rsp_id, req_ready, cfg_busy});
      end
      checks++;
      if (rsp_data !== '0 || pa_a !== '0) begin
         errors++;
         $display("FAIL reset_data: rsp_data %h pa_a %h want 0", rsp_data[63:0], pa_a[63:0]);
      end
      checks++;
      if (pa_m !== '0 || pa_m_n !== '0 || pa_m_prime !== '0) begin
         errors++;
         $display("FAIL reset_cfg: pa_m %h pa_m_prime %h want 0", pa_m[63:0], pa_m_prime);
      end
      cfg_m = M;
      cfg_m_n = m_n_exp;
      cfg_m_prime = M_PRIME;
      cfg_we = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0;
      #1;
      checks++;
      if (pa_m !== M || pa_m_n !== m_n_exp || pa_m_prime !== M_PRIME) begin
         errors++;
         $display("FAIL cfg_load: pa_m %h pa_m_n %h pa_m_prime %h", pa_m[63:0],
                  pa_m_n[63:0], pa_m_prime);
      end
      checks++;
      if (cfg_busy !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL cfg_idle: cfg_busy %b rsp_valid %b want 0 0", cfg_busy, rsp_valid);
      end
   endtask

   task automatic test_single;
      int n;
      int gap;
      bit bad;
      start_req(2, Size'(16'h1234));
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL single_grant: got %b want 0100", req_ready);
      end
      @(posedge clk);
      @(negedge clk); #1;
      req_valid = '0;
      checks++;
      if (req_ready !== '0 || pa_a !== Size'(16'h1234)) begin
         errors++;
         $display("FAIL single_issue: req_ready %b pa_a %h", req_ready, pa_a[63:0]);
      end
      n = 0;
      while (pa_en && n < 1000) begin
         n++;
         @(negedge clk); #1;
      end
      checks++;
      if (n != 20) begin
         errors++;
         $display("FAIL single_en_len: got %0d want 20", n);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(2) || rsp_err !== 1'b0
          || rsp_data !== Size'(16'h1234) + OFF) begin
         errors++;
         $display("FAIL single_rsp: v %b id %0d err %b data %h", rsp_valid, rsp_id,
                  rsp_err, rsp_data[63:0]);
      end
      start_req(3, opnd(3));
      measure_gap(gap, bad);
      checks++;
      if (gap != GAP || bad) begin
         errors++;
         $display("FAIL single_gap: got %0d bad %b want %0d", gap, bad, GAP);
      end
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++;
         $display("FAIL single_wrap_grant: got %b want 1000", req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      wait_rsp("single2");
      checks++;
      if (rsp_id !== ID_W'(3) || rsp_data !== opnd(3) + OFF) begin
         errors++;
         $display("FAIL single2_rsp: id %0d data %h", rsp_id, rsp_data[63:0]);
      end
      repeat (GAP + 2) @(negedge clk);
   endtask

   task automatic test_rr;
      int exp_id;
      for (int i = 0; i < NUM_REQ; i++) start_req(i, opnd(i));
      #1;
      for (int k = 0; k < 8; k++) begin
         exp_id = k % NUM_REQ;
         wait_ready("rr");
         checks++;
         if (req_ready !== (NUM_REQ'(1) << exp_id)) begin
            errors++;
            $display("FAIL rr_order[%0d]: got %b want id %0d", k, req_ready, exp_id);
         end
         wait_rsp("rr");
         if (k == 7) req_valid = '0;
         checks++;
         if (rsp_id !== ID_W'(exp_id) || rsp_data !== opnd(exp_id) + OFF || rsp_err) begin
            errors++;
            $display("FAIL rr_rsp[%0d]: id %0d data %h err %b want id %0d", k, rsp_id,
                     rsp_data[63:0], rsp_err, exp_id);
         end
      end
      repeat (GAP + 2) @(negedge clk);
   endtask

   task automatic test_hold;
      int gap;
      bit bad;
      start_req(0, opnd(9));
      #1;
      wait_ready("hold");
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      rsp_ready = 1'b0;
      start_req(1, opnd(10));
      wait_rsp("hold");
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(0) || rsp_data !== opnd(9) + OFF
             || req_ready !== '0 || pa_en !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable[%0d]: v %b id %0d data %h ready %b en %b", i,
                     rsp_valid, rsp_id, rsp_data[63:0], req_ready, pa_en);
         end
         @(negedge clk); #1;
      end
      rsp_ready = 1'b1;
      measure_gap(gap, bad);
      checks++;
      if (gap != GAP || bad || req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL hold_gap: gap %0d bad %b ready %b want %0d 0 0010", gap, bad,
                  req_ready, GAP);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      wait_rsp("hold2");
      checks++;
      if (rsp_id !== ID_W'(1) || rsp_data !== opnd(10) + OFF) begin
         errors++;
         $display("FAIL hold2_rsp: id %0d data %h", rsp_id, rsp_data[63:0]);
      end
      repeat (GAP + 2) @(negedge clk);
   endtask

   task automatic test_timeout;
      int n;
      model_on = 1'b0;
      start_req(2, opnd(20));
      #1;
      wait_ready("to");
      @(posedge clk);
      @(negedge clk); #1;
      req_valid = '0;
      n = 0;
      while (pa_en && n < 1000) begin
         n++;
         @(negedge clk); #1;
      end
      checks++;
      if (n != TIMEOUT + 1) begin
         errors++;
         $display("FAIL to_en_len: got %0d want %0d", n, TIMEOUT + 1);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0
          || rsp_id !== ID_W'(2) || pa_en !== 1'b0) begin
         errors++;
         $display("FAIL to_rsp: v %b err %b data %h id %0d en %b", rsp_valid, rsp_err,
                  rsp_data[63:0], rsp_id, pa_en);
      end
      model_on = 1'b1;
      start_req(3, opnd(21));
      wait_ready("to_next");
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      wait_rsp("to_next");
      checks++;
      if (rsp_err !== 1'b0 || rsp_id !== ID_W'(3) || rsp_data !== opnd(21) + OFF) begin
         errors++;
         $display("FAIL to_next_rsp: err %b id %0d data %h", rsp_err, rsp_id,
                  rsp_data[63:0]);
      end
      repeat (GAP + 2) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      bit bad;
      start_req(0, opnd(30));
      #1;
      wait_ready("rst");
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      repeat (3) @(negedge clk);
      cfg_m = Size'(8'h77);
      cfg_m_prime = (radix+2)'(9);
      cfg_we = 1'b1;
      #1;
      checks++;
      if (cfg_busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_cfg_busy: got %b want 1", cfg_busy);
      end
      @(negedge clk);
      cfg_we = 1'b0;
      #1;
      checks++;
      if (pa_m !== M || pa_m_prime !== M_PRIME || pa_en !== 1'b1) begin
         errors++;
         $display("FAIL rst_cfg_locked: pa_m %h pa_m_prime %h en %b", pa_m[63:0],
                  pa_m_prime, pa_en);
      end
      rst = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (pa_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== '0) begin
         errors++;
         $display("FAIL rst_abort: en %b v %b ready %b want 0", pa_en, rsp_valid, req_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      extra_en_out = 1'b1;
      @(negedge clk);
      extra_en_out = 1'b0;
      bad = 1'b0;
      repeat (5) begin
         @(negedge clk); #1;
         if (rsp_valid || pa_en) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL rst_no_rsp: stray response or enable after reset");
      end
      start_req(0, opnd(31));
      start_req(1, opnd(32));
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL rst_rr_ptr: got %b want 0001", req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      wait_rsp("rst_after");
      checks++;
      if (rsp_id !== ID_W'(0) || rsp_data !== opnd(31) + OFF || rsp_err) begin
         errors++;
         $display("FAIL rst_after_rsp: id %0d data %h err %b", rsp_id, rsp_data[63:0],
                  rsp_err);
      end
      repeat (GAP + 2) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      cfg_we = 1'b0;
      cfg_m = '0;
      cfg_m_n = '0;
      cfg_m_prime = '0;
      req_valid = '0;
      req_a = '0;
      rsp_ready = 1'b1;
      extra_en_out = 1'b0;
      model_on = 1'b1;
      model_lat = 20;
      m_n_exp = ~{2'b00, M} + 1'b1;
      test_reset();
      test_single();
      test_rr();
      test_hold();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/phase_a_scheduler.md
Name: phase_a_scheduler

Overview:
- Shares one phase_a reduction unit among NUM_REQ requesters using round-robin arbitration.
- Holds the shared modulus configuration (m, m_n, m_prime) and locks it while an operation is in flight.
- Registers the granted operand, pulses the unit's level-sensitive enable, waits for completion with a watchdog, and returns the result with a valid/ready response.

Parameters:
- Size, 3072, operand/modulus width.
- radix, 54, digit width; m_prime is radix+2 bits.
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester index width, equal to clog2(NUM_REQ).
- TIMEOUT, 255, maximum cycles from enable to en_out before error.
- GAP, 2, minimum enable-low cycles between operations.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  load configuration
- cfg_m  in  Size  modulus
- cfg_m_n  in  Size+2  negated modulus
- cfg_m_prime  in  radix+2  Montgomery constant
- cfg_busy  out  1  high when a cfg_we would be ignored
- req_valid  in  NUM_REQ  per-requester request
- req_a  in  NUM_REQ*Size  operands; slice i is requester i
- req_ready  out  NUM_REQ  one-hot grant/accept
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  ID_W  requester index
- rsp_data  out  Size  result (new_a)
- rsp_err  out  1  watchdog expired; rsp_data is 0
- pa_a  out  Size  operand to unit
- pa_m  out  Size  modulus to unit
- pa_m_n  out  Size+2  negated modulus to unit
- pa_m_prime  out  radix+2  Montgomery constant to unit
- pa_en  out  1  unit enable (level)
- pa_new_a  in  Size  unit result
- pa_en_out  in  1  unit completion pulse

Behaviour:
- Reset clears every register:
  - All outputs are 0, config registers are 0, state is IDLE.
  - RR pointer is 0, so requester 0 has highest priority first.
  - Reset asserted mid-operation abandons the operation with no response; pa_en drops in the next cycle.
- FSM states: IDLE, RUN, RESP, GAP.
- IDLE:
  - If any req_valid is set, grant the first requester at or after the RR pointer, wrapping.
  - req_ready[g] is asserted combinationally for that one cycle and the transfer happens in that cycle.
  - req_a slice g is captured into pa_a and g into rsp_id; pa_en becomes 1 and the FSM goes to RUN.
  - The RR pointer becomes (g+1) mod NUM_REQ.
  - If no request is pending, remain in IDLE.
- RUN:
  - Hold pa_en=1; pa_a and config are held stable.
  - The watchdog counter starts at 0 on entry and increments every cycle.
  - On pa_en_out=1: capture pa_new_a into rsp_data, rsp_err=0, pa_en=0, go to RESP.
  - Else if the counter reaches TIMEOUT: rsp_data=0, rsp_err=1, pa_en=0, go to RESP.
  - pa_en_out takes priority over timeout in the same cycle.
- RESP:
  - rsp_valid=1 with data, id and err stable until rsp_ready=1.
  - In the cycle with rsp_ready=1, rsp_valid deasserts on the next edge and the FSM goes to GAP.
- GAP:
  - pa_en=0 for exactly GAP cycles; this guarantees the unit's rising-edge detector re-arms.
  - Then go to IDLE.
  - No grants occur in RESP or GAP.
- Per-operation throughput ≥ 1 + unit latency + 1 + GAP cycles.
- Configuration:
  - cfg_we is accepted only in IDLE with no grant in the same cycle; cfg_busy = (state != IDLE) | (|req_valid).
  - cfg_we while busy is silently dropped.
  - The pa_m, pa_m_n and pa_m_prime outputs come directly from the config registers.
  - A config load and a grant never coincide because a grant implies busy.
- pa_en_out arriving outside RUN is ignored.
- req_valid dropping before grant is legal, and that request is simply not served.
- Only one operation is in flight at a time.

Test Plan:
- Reset, then load config (m=0xF…F1, m_prime=0x3) with no requests. Config outputs must match; cfg_busy=0; all response outputs 0.
- Single request from requester 2 with a=0x1234. Requires req_ready=4'b0100 for one cycle and pa_en high until a model en_out after 20 cycles. Then rsp_valid with rsp_id=2, rsp_data=model value, rsp_err=0. pa_en stays low for 2 cycles before the next grant.
- All 4 requests held continuously for 8 operations. Grant order must be 0,1,2,3,0,1,2,3, with each response matching its id.
- Hold rsp_ready=0 for 10 cycles. rsp_valid, data and id must be stable, with no new grant. On ready=1, GAP follows.
- Model never pulses en_out. After TIMEOUT=255 cycles: rsp_err=1, rsp_data=0, pa_en=0. The next request is then served normally.
- Assert rst during RUN, then raise en_out later. Requires no response, pa_en=0 next cycle, and the RR pointer reset to 0. cfg_we pulsed during RUN leaves config unchanged.
